dac_point_scheduler: RTL and testbench

- Sequences (x,y) points from upstream vector logic into the single-channel-at-a-time MCP4922 SPI driver.
- Buffers points in a small FIFO and issues an X write then a Y write per point through the driver's strobe/ready handshake.
- Holds each point for a programmable dwell time.
- Flags underrun when the beam would otherwise sit idle mid-stream.

---
 rtl/dac_pkg.sv | 26 ++
 rtl/point_fifo.sv | 67 ++++++
 rtl/dac_point_scheduler.sv | 175 +++++++++++++++++
 tb/tb_dac_point_scheduler.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC point scheduler: FSM state encoding,
// DAC word width, axis select values and the buffered point layout.
package dac_pkg;

  localparam int DAC_VALUE_W = 12;
  localparam int POINT_W     = 2 * DAC_VALUE_W;

  // Axis select as seen by the MCP4922 driver: X on channel B, Y on channel A.
  localparam logic DAC_AXIS_X = 1'b1;
  localparam logic DAC_AXIS_Y = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_X_SEND,
    ST_X_WAIT,
    ST_Y_SEND,
    ST_Y_WAIT,
    ST_DWELL
  } state_t;

  typedef struct packed {
    logic [DAC_VALUE_W-1:0] x;
    logic [DAC_VALUE_W-1:0] y;
  } point_t;

endpackage

// File: rtl/point_fifo.sv
// Point FIFO: DEPTH entries of one (x,y) point each, synchronous push/pop,
// combinational head read, occupancy count, asynchronous active-high reset.
//   clk, reset        clock and async reset
//   push_i, push_data_i  write request and point; ignored when full
//   pop_i             read request; ignored when empty
//   head_o            oldest entry, valid whenever empty_o is low
//   fill_o            number of stored entries (0..DEPTH)
//   full_o, empty_o   occupancy flags
module point_fifo
  import dac_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  point_t                 push_data_i,
  input  logic                   pop_i,
  output point_t                 head_o,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  point_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     fill_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (fill_q == FULL_CNT);
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push is refused whenever full, even if a pop frees a slot this cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   fill_q <= fill_q + (AW+1)'(1);
        2'b01:   fill_q <= fill_q - (AW+1)'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: rtl/dac_point_scheduler.sv
// DAC point scheduler: buffers (x,y) points and feeds them one axis at a time
// into the MCP4922 SPI driver, then holds each point for a dwell time.
//   clk, reset                      clock and async active-high reset
//   point_x/y, point_valid/ready    upstream point stream (valid/ready)
//   dwell                           extra hold cycles, sampled on DWELL entry
//   enable                          low: finish current point, then park in IDLE
//   underrun_clr                    clears the sticky underrun flag
//   dac_value, dac_axis, dac_strobe, dac_ready   driver handshake
//   fill, busy, underrun            status
//
// state   | meaning
// IDLE    | waiting for a point, enable and an idle driver
// X_SEND  | one-cycle strobe of the X value
// X_WAIT  | driver busy with X, wait for ready
// Y_SEND  | one-cycle strobe of the Y value
// Y_WAIT  | driver busy with Y, wait for ready
// DWELL   | hold the point for the sampled dwell count
module dac_point_scheduler
  import dac_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int DWELL_W     = 16,
  parameter bit SKIP_SAME_X = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DAC_VALUE_W-1:0] point_x,
  input  logic [DAC_VALUE_W-1:0] point_y,
  input  logic                   point_valid,
  output logic                   point_ready,
  input  logic [DWELL_W-1:0]     dwell,
  input  logic                   enable,
  input  logic                   underrun_clr,
  output logic [DAC_VALUE_W-1:0] dac_value,
  output logic                   dac_axis,
  output logic                   dac_strobe,
  input  logic                   dac_ready,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   busy,
  output logic                   underrun
);

  state_t                 state_q;
  point_t                 push_pt;
  point_t                 head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   skip_x;
  logic [DAC_VALUE_W-1:0] cur_x_q;
  logic [DAC_VALUE_W-1:0] cur_y_q;
  logic [DAC_VALUE_W-1:0] last_x_q;
  logic                   last_x_vld_q;
  logic [DWELL_W-1:0]     dwell_cnt_q;
  logic                   strobe_q;
  logic                   axis_q;
  logic [DAC_VALUE_W-1:0] value_q;
  logic                   popped_q;
  logic                   popped_d;
  logic                   underrun_q;
  logic                   underrun_d;

  assign push_pt     = '{x: point_x, y: point_y};
  assign point_ready = !fifo_full;

  point_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (point_valid),
    .push_data_i (push_pt),
    .pop_i       (pop),
    .head_o      (head),
    .fill_o      (fill),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Popping only with the driver idle keeps the IDLE->SEND strobe legal.
  assign pop    = (state_q == ST_IDLE) && enable && !fifo_empty && dac_ready;
  assign skip_x = SKIP_SAME_X && last_x_vld_q && (head.x == last_x_q);

  // popped_q remembers that the stream has started, so an empty FIFO at
  // power-up or after a clear is not reported as an underrun.
  always_comb begin
    popped_d = popped_q;
    if (underrun_clr) popped_d = 1'b0;
    if (pop)          popped_d = 1'b1;

    underrun_d = underrun_q;
    if ((state_q == ST_IDLE) && enable && fifo_empty && popped_q) underrun_d = 1'b1;
    if (underrun_clr) underrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      last_x_q     <= '0;
      last_x_vld_q <= 1'b0;
      dwell_cnt_q  <= '0;
      strobe_q     <= 1'b0;
      axis_q       <= DAC_AXIS_Y;
      value_q      <= '0;
      popped_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      popped_q   <= popped_d;
      underrun_q <= underrun_d;
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            cur_x_q  <= head.x;
            cur_y_q  <= head.y;
            strobe_q <= 1'b1;
            if (skip_x) begin
              state_q <= ST_Y_SEND;
              axis_q  <= DAC_AXIS_Y;
              value_q <= head.y;
            end else begin
              state_q <= ST_X_SEND;
              axis_q  <= DAC_AXIS_X;
              value_q <= head.x;
            end
          end
        end
        ST_X_SEND: begin
          strobe_q     <= 1'b0;
          last_x_q     <= cur_x_q;
          last_x_vld_q <= 1'b1;
          state_q      <= ST_X_WAIT;
        end
        // The driver drops ready the cycle after a strobe, so ready seen
        // here always means the previous transfer has finished.
        ST_X_WAIT: begin
          if (dac_ready) begin
            strobe_q <= 1'b1;
            axis_q   <= DAC_AXIS_Y;
            value_q  <= cur_y_q;
            state_q  <= ST_Y_SEND;
          end
        end
        ST_Y_SEND: begin
          strobe_q <= 1'b0;
          state_q  <= ST_Y_WAIT;
        end
        ST_Y_WAIT: begin
          if (dac_ready) begin
            if (dwell == '0) begin
              state_q <= ST_IDLE;
            end else begin
              dwell_cnt_q <= dwell;
              state_q     <= ST_DWELL;
            end
          end
        end
        ST_DWELL: begin
          dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
          if (dwell_cnt_q == DWELL_W'(1)) state_q <= ST_IDLE;
        end
        default: begin
          strobe_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign dac_strobe = strobe_q;
  assign dac_axis   = axis_q;
  assign dac_value  = value_q;
  assign busy       = (state_q != ST_IDLE);
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_point_scheduler.sv
module tb_dac_point_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  // main instance (SKIP_SAME_X=1)
  logic [11:0] point_x, point_y, dac_value;
  logic        point_valid, point_ready, enable, underrun_clr;
  logic        dac_axis, dac_strobe, dac_ready, busy, underrun;
  logic [15:0] dwell;
  logic [4:0]  fill;
  // second instance (SKIP_SAME_X=0)
  logic [11:0] ns_point_x, ns_point_y, ns_dac_value;
  logic        ns_point_valid, ns_point_ready, ns_dac_axis, ns_dac_strobe;
  logic        ns_dac_ready, ns_busy, ns_underrun;
  logic [4:0]  ns_fill;

  dac_point_scheduler #(.DEPTH(16), .DWELL_W(16), .SKIP_SAME_X(1'b1)) dut (
    .clk(clk), .reset(reset), .point_x(point_x), .point_y(point_y),
    .point_valid(point_valid), .point_ready(point_ready), .dwell(dwell),
    .enable(enable), .underrun_clr(underrun_clr), .dac_value(dac_value),
    .dac_axis(dac_axis), .dac_strobe(dac_strobe), .dac_ready(dac_ready),
    .fill(fill), .busy(busy), .underrun(underrun));

  dac_point_scheduler #(.DEPTH(16), .DWELL_W(16), .SKIP_SAME_X(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .point_x(ns_point_x), .point_y(ns_point_y),
    .point_valid(ns_point_valid), .point_ready(ns_point_ready), .dwell(dwell),
    .enable(enable), .underrun_clr(underrun_clr), .dac_value(ns_dac_value),
    .dac_axis(ns_dac_axis), .dac_strobe(ns_dac_strobe), .dac_ready(ns_dac_ready),
    .fill(ns_fill), .busy(ns_busy), .underrun(ns_underrun));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver model: after a strobe, ready is low until drv_delay negedges pass.
  int   drv_delay = 3;
  logic drv_hold = 1'b0;
  logic rdy_int = 1'b1, ns_rdy_int = 1'b1;
  int   rdy_cnt = 0, ns_rdy_cnt = 0;
  logic prev_strobe = 1'b0, ns_prev_strobe = 1'b0;
  int   viol_lowrdy = 0, viol_b2b = 0, ns_viol_lowrdy = 0, ns_viol_b2b = 0;
  logic [12:0] obs_q[$];
  int          obs_t[$];
  logic [12:0] ns_obs_q[$];
  logic [12:0] exp_q[$];
  logic [11:0] mdl_lastx = 12'h0;
  bit          mdl_lastx_vld = 1'b0;

  assign dac_ready    = rdy_int & ~drv_hold;
  assign ns_dac_ready = ns_rdy_int;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      rdy_int = 1'b1; rdy_cnt = 0; prev_strobe = 1'b0;
    end else begin
      if (dac_strobe) begin
        if (!dac_ready) viol_lowrdy++;
        if (prev_strobe) viol_b2b++;
        obs_q.push_back({dac_axis, dac_value});
        obs_t.push_back(cyc);
        rdy_int = 1'b0; rdy_cnt = drv_delay;
      end else if (rdy_cnt > 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0) rdy_int = 1'b1;
      end
      prev_strobe = dac_strobe;
    end
  end

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      ns_rdy_int = 1'b1; ns_rdy_cnt = 0; ns_prev_strobe = 1'b0;
    end else begin
      if (ns_dac_strobe) begin
        if (!ns_dac_ready) ns_viol_lowrdy++;
        if (ns_prev_strobe) ns_viol_b2b++;
        ns_obs_q.push_back({ns_dac_axis, ns_dac_value});
        ns_rdy_int = 1'b0; ns_rdy_cnt = drv_delay;
      end else if (ns_rdy_cnt > 0) begin
        ns_rdy_cnt--;
        if (ns_rdy_cnt == 0) ns_rdy_int = 1'b1;
      end
      ns_prev_strobe = ns_dac_strobe;
    end
  end

  // Reference: each point writes X unless it repeats the last X written, then Y.
  task automatic mdl_point(input logic [11:0] x, input logic [11:0] y);
    if (!(mdl_lastx_vld && x == mdl_lastx)) begin
      exp_q.push_back({1'b1, x});
      mdl_lastx = x;
      mdl_lastx_vld = 1'b1;
    end
    exp_q.push_back({1'b0, y});
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_main(input logic [11:0] x, input logic [11:0] y, output bit acc);
    point_x = x; point_y = y; point_valid = 1'b1;
    acc = point_ready;
    tick();
    point_valid = 1'b0;
    if (acc) mdl_point(x, y);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && fill == 5'd0 && dac_ready) begin ok = 1'b1; break; end
      tick();
    end
    tick();
  endtask

  task automatic clear_all();
    obs_q.delete(); obs_t.delete(); exp_q.delete(); ns_obs_q.delete();
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
  endtask

  task automatic test_reset();
    for (int ph = 0; ph < 2; ph++) begin
      vectors++;
      if ({point_ready, dac_strobe, dac_axis, dac_value, fill, busy, underrun} !== {1'b1, 1'b0, 1'b0, 12'h0, 5'd0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_state ph%0d: got rdy=%b stb=%b ax=%b val=%h fill=%0d busy=%b ur=%b want 1 0 0 000 0 0 0",
                 ph, point_ready, dac_strobe, dac_axis, dac_value, fill, busy, underrun);
      end
      vectors++;
      if ({ns_fill, ns_busy, ns_dac_strobe} !== 7'd0) begin
        miscompares++;
        $display("FAIL reset_ns ph%0d: got fill=%0d busy=%b stb=%b want 0 0 0", ph, ns_fill, ns_busy, ns_dac_strobe);
      end
      reset = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic test_basic();
    bit a, ok;
    drv_delay = 33; dwell = 16'd0;
    clear_all();
    push_main(12'h100, 12'h200, a);
    vectors++;
    if (underrun !== 1'b0) begin miscompares++; $display("FAIL basic_early_underrun: got %b want 0", underrun); end
    wait_idle(400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL basic_timeout: got busy=%b fill=%0d want idle", busy, fill); end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL basic_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_t.size() >= 2) begin
      vectors++;
      if (obs_t[1] - obs_t[0] != 34) begin miscompares++; $display("FAIL basic_gap: got %0d want 34", obs_t[1] - obs_t[0]); end
    end
    vectors++;
    if (underrun !== 1'b1) begin miscompares++; $display("FAIL basic_underrun_set: got %b want 1", underrun); end
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    vectors++;
    if (underrun !== 1'b0) begin miscompares++; $display("FAIL basic_underrun_clr: got %b want 0", underrun); end
    repeat (5) tick();
    vectors++;
    if (underrun !== 1'b0) begin miscompares++; $display("FAIL basic_underrun_stays_clear: got %b want 0", underrun); end
  endtask

  task automatic test_skip();
    bit a, ok;
    logic [12:0] ns_exp [4];
    ns_exp[0] = {1'b1, 12'h123}; ns_exp[1] = {1'b0, 12'h010};
    ns_exp[2] = {1'b1, 12'h123}; ns_exp[3] = {1'b0, 12'h020};
    drv_delay = $urandom_range(1, 4);
    clear_all();
    push_main(12'h123, 12'h010, a);
    push_main(12'h123, 12'h020, a);
    wait_idle(300, ok);
    vectors++;
    if (!ok || obs_q.size() != 3 || exp_q.size() != 3) begin
      miscompares++; $display("FAIL skip_count: got %0d strobes ok=%b want 3", obs_q.size(), ok);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL skip_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    ns_point_x = 12'h123; ns_point_y = 12'h010; ns_point_valid = 1'b1; tick();
    ns_point_y = 12'h020; tick();
    ns_point_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!ns_busy && ns_fill == 5'd0 && ns_dac_ready) begin ok = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!ok || ns_obs_q.size() != 4) begin miscompares++; $display("FAIL noskip_count: got %0d strobes ok=%b want 4", ns_obs_q.size(), ok); end
    for (int i = 0; i < ns_obs_q.size() && i < 4; i++) begin
      vectors++;
      if (ns_obs_q[i] !== ns_exp[i]) begin miscompares++; $display("FAIL noskip_stream[%0d]: got %h want %h", i, ns_obs_q[i], ns_exp[i]); end
    end
  endtask

  task automatic test_full();
    bit a, ok;
    drv_delay = $urandom_range(1, 4);
    clear_all();
    drv_hold = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      push_main(12'($urandom), 12'($urandom), a);
      vectors++;
      if (a !== (i < 16)) begin miscompares++; $display("FAIL full_accept[%0d]: got %b want %b", i, a, (i < 16)); end
      if (i == 15) begin
        vectors++;
        if (fill !== 5'd16 || point_ready !== 1'b0) begin
          miscompares++; $display("FAIL full_flags: got fill=%0d rdy=%b want 16 0", fill, point_ready);
        end
      end
    end
    point_x = 12'hABC; point_y = 12'hDEF; point_valid = 1'b1; drv_hold = 1'b0;
    tick();
    point_valid = 1'b0;
    vectors++;
    if (fill !== 5'd15) begin miscompares++; $display("FAIL full_pop_no_push: got fill=%0d want 15", fill); end
    wait_idle(3000, ok);
    vectors++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL full_count: got %0d want %0d ok=%b", obs_q.size(), exp_q.size(), ok);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL full_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit a, ok;
    int d, dw, g;
    d = $urandom_range(1, 5); dw = $urandom_range(0, 3);
    drv_delay = d; dwell = 16'(dw);
    clear_all();
    for (int i = 0; i < 20; i++) push_main(12'h111 * 12'($urandom_range(0, 3)), 12'($urandom), a);
    wait_idle(3000, ok);
    vectors++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rand_count: got %0d want %0d ok=%b", obs_q.size(), exp_q.size(), ok);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      if (i > 0) begin
        g = exp_q[i-1][12] ? d + 1 : d + 2 + dw;
        vectors++;
        if (obs_t[i] - obs_t[i-1] != g) begin
          miscompares++; $display("FAIL rand_gap[%0d]: got %0d want %0d (d=%0d dwell=%0d)", i, obs_t[i] - obs_t[i-1], g, d, dw);
        end
      end
    end
    dwell = 16'd0;
  endtask

  task automatic test_dwell();
    bit a, ok;
    int want [3];
    drv_delay = 2; dwell = 16'd5;
    want[0] = 3; want[1] = 9; want[2] = 3;
    clear_all();
    push_main(12'h3A0, 12'h011, a);
    push_main(12'h3A1, 12'h022, a);
    for (int i = 0; i < 200 && obs_q.size() < 2; i++) tick();
    repeat (4) tick();
    dwell = 16'd100;
    wait_idle(600, ok);
    dwell = 16'd0;
    vectors++;
    if (!ok || obs_q.size() != 4 || exp_q.size() != 4) begin
      miscompares++; $display("FAIL dwell_count: got %0d want 4 ok=%b", obs_q.size(), ok);
    end
    for (int i = 1; i < obs_t.size() && i < 4; i++) begin
      vectors++;
      if (obs_t[i] - obs_t[i-1] != want[i-1]) begin
        miscompares++; $display("FAIL dwell_gap[%0d]: got %0d want %0d", i, obs_t[i] - obs_t[i-1], want[i-1]);
      end
    end
  endtask

  task automatic test_enable();
    bit a, ok;
    drv_delay = 6; dwell = 16'd0;
    clear_all();
    enable = 1'b0;
    push_main(12'h700, 12'h010, a);
    push_main(12'h701, 12'h020, a);
    push_main(12'h702, 12'h030, a);
    vectors++;
    if (fill !== 5'd3 || busy !== 1'b0) begin miscompares++; $display("FAIL enable_park: got fill=%0d busy=%b want 3 0", fill, busy); end
    enable = 1'b1;
    for (int i = 0; i < 50 && obs_q.size() < 1; i++) tick();
    tick();
    enable = 1'b0;
    for (int i = 0; i < 100 && busy; i++) tick();
    repeat (10) tick();
    vectors++;
    if (obs_q.size() != 2 || fill !== 5'd2 || busy !== 1'b0 || underrun !== 1'b0) begin
      miscompares++; $display("FAIL enable_stop: got strobes=%0d fill=%0d busy=%b ur=%b want 2 2 0 0", obs_q.size(), fill, busy, underrun);
    end
    enable = 1'b1;
    wait_idle(400, ok);
    vectors++;
    if (!ok || obs_q.size() != 6) begin miscompares++; $display("FAIL enable_resume_count: got %0d want 6 ok=%b", obs_q.size(), ok); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL enable_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++;
    if (underrun !== 1'b1) begin miscompares++; $display("FAIL enable_underrun: got %b want 1", underrun); end
  endtask

  task automatic test_reset_mid();
    bit a, ok;
    drv_delay = 8;
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    push_main(12'h555, 12'h0AA, a);
    push_main(12'h556, 12'h0BB, a);
    for (int i = 0; i < 100 && obs_q.size() < 2; i++) tick();
    tick();
    vectors++;
    if (busy !== 1'b1 || fill !== 5'd1 || underrun !== 1'b1) begin
      miscompares++; $display("FAIL midreset_pre: got busy=%b fill=%0d ur=%b want 1 1 1", busy, fill, underrun);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({dac_strobe, fill, busy, underrun, point_ready} !== {1'b0, 5'd0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL midreset_async: got stb=%b fill=%0d busy=%b ur=%b rdy=%b want 0 0 0 0 1",
                              dac_strobe, fill, busy, underrun, point_ready);
    end
    tick();
    reset = 1'b0;
    mdl_lastx_vld = 1'b0;
    tick();
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    push_main(12'h556, 12'h0CC, a);
    wait_idle(300, ok);
    vectors++;
    if (!ok || obs_q.size() != 2) begin miscompares++; $display("FAIL midreset_count: got %0d want 2 ok=%b", obs_q.size(), ok); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL midreset_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_protocol();
    vectors++;
    if (viol_lowrdy != 0 || viol_b2b != 0) begin
      miscompares++; $display("FAIL strobe_rules: got lowrdy=%0d b2b=%0d want 0 0", viol_lowrdy, viol_b2b);
    end
    vectors++;
    if (ns_viol_lowrdy != 0 || ns_viol_b2b != 0) begin
      miscompares++; $display("FAIL ns_strobe_rules: got lowrdy=%0d b2b=%0d want 0 0", ns_viol_lowrdy, ns_viol_b2b);
    end
  endtask

  initial begin
    point_valid = 1'b0; point_x = '0; point_y = '0;
    ns_point_valid = 1'b0; ns_point_x = '0; ns_point_y = '0;
    dwell = 16'd0; enable = 1'b1; underrun_clr = 1'b0;
    #2 reset = 1'b1;
    repeat (3) tick();
    test_reset();
    test_basic();
    test_skip();
    test_full();
    test_random();
    test_dwell();
    test_enable();
    test_reset_mid();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
